// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: sequences start/data/parity/stop fields from the
// oversampling sampler's bit strobes into a one-entry holding register with error flags.
module uart_rx_frame_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 smp_bit,
    input  logic                 smp_valid,
    output logic                 smp_stop,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    input  logic                 err_clr
);
    localparam int CW  = $clog2(DATA_BITS + 1);
    localparam int SCW = $clog2(STOP_BITS + 1);
    localparam logic P_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    state_t               state, state_nxt;
    logic                 stop_nxt;
    logic [CW-1:0]        cnt;
    logic [SCW-1:0]       scnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 data_xor;
    logic                 perr_frame;
    logic                 ferr_frame;
    logic                 load;
    logic                 ovr_set;

    always_comb begin
        state_nxt = state;
        stop_nxt  = 1'b0;
        case (state)
            IDLE:   if (en) state_nxt = START;
            START:
                if (smp_valid) begin
                    if (!smp_bit) begin
                        state_nxt = DATA;
                    end else begin
                        stop_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            DATA:
                if (smp_valid && cnt == CW'(DATA_BITS - 1))
                    state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY: if (smp_valid) state_nxt = STOP;
            STOP:
                // smp_stop is raised while in DONE so it can never abut a false-start pulse
                if (smp_valid && scnt == SCW'(STOP_BITS - 1)) begin
                    stop_nxt  = 1'b1;
                    state_nxt = DONE;
                end
            DONE:    state_nxt = en ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign load    = (state == DONE);
    assign ovr_set = load && rx_valid && !rx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            smp_stop    <= 1'b0;
            cnt         <= '0;
            scnt        <= '0;
            shreg       <= '0;
            data_xor    <= 1'b0;
            perr_frame  <= 1'b0;
            ferr_frame  <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            smp_stop <= stop_nxt;
            case (state)
                START:
                    if (smp_valid && !smp_bit) begin
                        cnt        <= '0;
                        scnt       <= '0;
                        shreg      <= '0;
                        data_xor   <= 1'b0;
                        perr_frame <= 1'b0;
                        ferr_frame <= 1'b0;
                    end
                DATA:
                    if (smp_valid) begin
                        shreg    <= {smp_bit, shreg[DATA_BITS-1:1]};
                        cnt      <= cnt + 1'b1;
                        data_xor <= data_xor ^ smp_bit;
                    end
                PARITY:
                    if (smp_valid && (smp_bit != (data_xor ^ P_ODD))) perr_frame <= 1'b1;
                STOP:
                    if (smp_valid) begin
                        if (!smp_bit) ferr_frame <= 1'b1;
                        scnt <= scnt + 1'b1;
                    end
                default: ;
            endcase

            // A load with a same-cycle accept replaces the word; without one it is an overrun.
            if (load) begin
                if (!ovr_set) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            frame_err   <= (frame_err   & ~err_clr) | (load & ferr_frame);
            parity_err  <= (parity_err  & ~err_clr) | (load & perr_frame);
            overrun_err <= (overrun_err & ~err_clr) | ovr_set;
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: an 8N1 instance and an 8E2 instance driven by
// directed and randomized frames, checked against a frame-level model.
module tb_uart_rx_frame_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8N1 instance
    logic       n_en, n_bit, n_valid, n_ready, n_clr;
    logic       n_stop, n_rxv, n_ferr, n_perr, n_oerr;
    logic [7:0] n_data;
    // 8E2 instance
    logic       p_en, p_bit, p_valid, p_ready, p_clr;
    logic       p_stop, p_rxv, p_ferr, p_perr, p_oerr;
    logic [7:0] p_data;

    uart_rx_frame_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_n (
        .clk(clk), .rst(rst), .en(n_en), .smp_bit(n_bit), .smp_valid(n_valid),
        .smp_stop(n_stop), .rx_data(n_data), .rx_valid(n_rxv), .rx_ready(n_ready),
        .frame_err(n_ferr), .parity_err(n_perr), .overrun_err(n_oerr), .err_clr(n_clr));

    uart_rx_frame_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_p (
        .clk(clk), .rst(rst), .en(p_en), .smp_bit(p_bit), .smp_valid(p_valid),
        .smp_stop(p_stop), .rx_data(p_data), .rx_valid(p_rxv), .rx_ready(p_ready),
        .frame_err(p_ferr), .parity_err(p_perr), .overrun_err(p_oerr), .err_clr(p_clr));

    int checks = 0;
    int failures = 0;
    int n_stops = 0, p_stops = 0;
    logic n_prev = 1'b0, p_prev = 1'b0, dbl = 1'b0;

    always @(negedge clk) begin
        if (n_stop) n_stops++;
        if (p_stop) p_stops++;
        if ((n_stop && n_prev) || (p_stop && p_prev)) dbl = 1'b1;
        n_prev = n_stop;
        p_prev = p_stop;
    end

    // ---------------- drivers ----------------
    task automatic strobe(input bit inst_p, input logic b, input bit gap);
        @(negedge clk);
        if (inst_p) begin p_bit = b; p_valid = 1'b1; end
        else        begin n_bit = b; n_valid = 1'b1; end
        @(negedge clk);
        p_valid = 1'b0;
        n_valid = 1'b0;
        if (gap) repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic send_n(input logic [7:0] d, input logic s);
        strobe(0, 1'b0, 1);
        for (int i = 0; i < 8; i++) strobe(0, d[i], 1);
        strobe(0, s, 0);
    endtask

    task automatic send_p(input logic [7:0] d, input logic pb, input logic s0, input logic s1);
        strobe(1, 1'b0, 1);
        for (int i = 0; i < 8; i++) strobe(1, d[i], 1);
        strobe(1, pb, 1);
        strobe(1, s0, 1);
        strobe(1, s1, 0);
    endtask

    task automatic wait_valid(input bit inst_p, input string name);
        int k;
        k = 0;
        while ((inst_p ? p_rxv : n_rxv) !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if ((inst_p ? p_rxv : n_rxv) !== 1'b1) begin
            failures++;
            $display("FAIL %s: rx_valid timeout got=%b want=1", name, inst_p ? p_rxv : n_rxv);
        end
    endtask

    task automatic accept(input bit inst_p, input string name);
        @(negedge clk);
        if (inst_p) p_ready = 1'b1; else n_ready = 1'b1;
        @(negedge clk);
        p_ready = 1'b0;
        n_ready = 1'b0;
        checks++;
        if ((inst_p ? p_rxv : n_rxv) !== 1'b0) begin
            failures++;
            $display("FAIL %s accept: rx_valid got=%b want=0", name, inst_p ? p_rxv : n_rxv);
        end
    endtask

    task automatic clear_errs();
        @(negedge clk);
        n_clr = 1'b1; p_clr = 1'b1;
        @(negedge clk);
        n_clr = 1'b0; p_clr = 1'b0;
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%b want=%b", name, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic exp_perr(input logic [7:0] d, input logic pb, input logic odd);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += d[i];
        // the parity bit makes the total count of ones even (or odd)
        return ((ones + pb) % 2) != (odd ? 1 : 0);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check1("reset n_stop", n_stop, 1'b0);
        check1("reset n_rxv", n_rxv, 1'b0);
        check8("reset n_data", n_data, 8'h00);
        check1("reset n_errs", n_ferr | n_perr | n_oerr, 1'b0);
        check1("reset p_rxv", p_rxv, 1'b0);
        check1("reset p_errs", p_ferr | p_perr | p_oerr, 1'b0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int s0;
        s0 = n_stops;
        send_n(8'hA5, 1'b1);
        wait_valid(0, "basic");
        check8("basic data", n_data, 8'hA5);
        check1("basic errs", n_ferr | n_perr | n_oerr, 1'b0);
        checks++;
        if (n_stops - s0 != 1) begin
            failures++;
            $display("FAIL basic stop pulses: got=%0d want=1", n_stops - s0);
        end
        accept(0, "basic");
    endtask

    task automatic test_false_start();
        int s0;
        s0 = n_stops;
        strobe(0, 1'b1, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (n_stops - s0 != 1) begin
            failures++;
            $display("FAIL false_start stop pulses: got=%0d want=1", n_stops - s0);
        end
        check1("false_start rxv", n_rxv, 1'b0);
        check1("false_start errs", n_ferr | n_perr | n_oerr, 1'b0);
    endtask

    task automatic test_framing();
        send_n(8'h3C, 1'b0);
        wait_valid(0, "framing");
        check8("framing data", n_data, 8'h3C);
        check1("framing ferr", n_ferr, 1'b1);
        accept(0, "framing");
        clear_errs();
        check1("framing clr", n_ferr, 1'b0);
    endtask

    task automatic test_parity();
        int s0;
        s0 = p_stops;
        send_p(8'h07, 1'b0, 1'b1, 1'b1);
        wait_valid(1, "parity bad");
        check8("parity bad data", p_data, 8'h07);
        check1("parity bad perr", p_perr, 1'b1);
        check1("parity bad ferr", p_ferr, 1'b0);
        accept(1, "parity bad");
        clear_errs();
        send_p(8'h07, 1'b1, 1'b1, 1'b1);
        wait_valid(1, "parity good");
        check1("parity good perr", p_perr, 1'b0);
        // second stop bit low must flag framing
        accept(1, "parity good");
        send_p(8'h80, 1'b1, 1'b1, 1'b0);
        wait_valid(1, "stop2");
        check1("stop2 ferr", p_ferr, 1'b1);
        check1("stop2 perr", p_perr, 1'b0);
        accept(1, "stop2");
        clear_errs();
        checks++;
        if (p_stops - s0 != 3) begin
            failures++;
            $display("FAIL parity stop pulses: got=%0d want=3", p_stops - s0);
        end
    endtask

    task automatic test_overrun();
        send_n(8'h11, 1'b1);
        wait_valid(0, "overrun first");
        send_n(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        check8("overrun data", n_data, 8'h11);
        check1("overrun flag", n_oerr, 1'b1);
        check1("overrun rxv", n_rxv, 1'b1);
        accept(0, "overrun");
        clear_errs();
        check1("overrun clr", n_oerr, 1'b0);
        // accept coinciding with the DONE load replaces the word without overrun
        send_n(8'h11, 1'b1);
        wait_valid(0, "replace first");
        strobe(0, 1'b0, 0);
        for (int i = 0; i < 8; i++) strobe(0, 1'(8'h22 >> i), 0);
        @(negedge clk);
        n_bit = 1'b1; n_valid = 1'b1;
        @(negedge clk);
        n_valid = 1'b0; n_ready = 1'b1;
        @(negedge clk);
        n_ready = 1'b0;
        check8("replace data", n_data, 8'h22);
        check1("replace rxv", n_rxv, 1'b1);
        check1("replace oerr", n_oerr, 1'b0);
        accept(0, "replace");
    endtask

    task automatic test_reset_mid();
        strobe(0, 1'b0, 0);
        for (int i = 0; i < 4; i++) strobe(0, 1'b1, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check1("rstmid rxv", n_rxv, 1'b0);
        check8("rstmid data", n_data, 8'h00);
        check1("rstmid stop", n_stop, 1'b0);
        @(negedge clk);
        send_n(8'h5A, 1'b1);
        wait_valid(0, "rstmid frame");
        check8("rstmid frame data", n_data, 8'h5A);
        check1("rstmid frame errs", n_ferr | n_oerr, 1'b0);
        accept(0, "rstmid");
    endtask

    task automatic test_en_off();
        int s0;
        strobe(0, 1'b0, 0);
        n_en = 1'b0;
        for (int i = 0; i < 8; i++) strobe(0, 1'(8'hC3 >> i), 0);
        strobe(0, 1'b1, 0);
        wait_valid(0, "en_off frame");
        check8("en_off data", n_data, 8'hC3);
        accept(0, "en_off");
        s0 = n_stops;
        strobe(0, 1'b0, 0);
        strobe(0, 1'b1, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (n_stops != s0) begin
            failures++;
            $display("FAIL en_off idle stop pulses: got=%0d want=0", n_stops - s0);
        end
        check1("en_off idle rxv", n_rxv, 1'b0);
        n_en = 1'b1;
        @(negedge clk);
        send_n(8'h96, 1'b1);
        wait_valid(0, "en_on frame");
        check8("en_on data", n_data, 8'h96);
        accept(0, "en_on");
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       s0, s1, pb, clr;
        logic       m_ferr_n = 1'b0, m_ferr_p = 1'b0, m_perr = 1'b0;
        for (int f = 0; f < 12; f++) begin
            d  = 8'($urandom);
            s0 = ($urandom_range(0, 3) != 0);
            send_n(d, s0);
            m_ferr_n = m_ferr_n | ~s0;
            wait_valid(0, "rand n");
            check8("rand n data", n_data, d);
            check1("rand n ferr", n_ferr, m_ferr_n);

            d  = 8'($urandom);
            pb = 1'($urandom);
            s0 = ($urandom_range(0, 3) != 0);
            s1 = ($urandom_range(0, 3) != 0);
            send_p(d, pb, s0, s1);
            m_ferr_p = m_ferr_p | ~s0 | ~s1;
            m_perr   = m_perr | exp_perr(d, pb, 1'b0);
            wait_valid(1, "rand p");
            check8("rand p data", p_data, d);
            check1("rand p ferr", p_ferr, m_ferr_p);
            check1("rand p perr", p_perr, m_perr);

            accept(0, "rand n");
            accept(1, "rand p");
            clr = 1'($urandom);
            if (clr) begin
                clear_errs();
                m_ferr_n = 1'b0; m_ferr_p = 1'b0; m_perr = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        n_en = 1'b1; n_bit = 1'b1; n_valid = 1'b0; n_ready = 1'b0; n_clr = 1'b0;
        p_en = 1'b1; p_bit = 1'b1; p_valid = 1'b0; p_ready = 1'b0; p_clr = 1'b0;
        test_reset();
        test_basic();
        test_false_start();
        test_framing();
        test_parity();
        test_overrun();
        test_reset_mid();
        test_en_off();
        test_random();
        check1("smp_stop never back-to-back", dbl, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
